// File: rtl/vram_port_arbiter_m_if.sv
// Requester-side bundle for vram_port_arbiter_m: a video read port and a CPU read/write port.
// Requesters use the master modport, the arbiter uses the slave modport.
interface vram_port_arbiter_m_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
);
  logic                  vid_valid;
  logic                  vid_ready;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [DATA_WIDTH-1:0] vid_rdata;
  logic                  vid_rvalid;

  logic                  cpu_valid;
  logic                  cpu_ready;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;

  modport master (
    output vid_valid, vid_addr,
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    input  vid_ready, vid_rdata, vid_rvalid,
    input  cpu_ready, cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  vid_valid, vid_addr,
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
    output vid_ready, vid_rdata, vid_rvalid,
    output cpu_ready, cpu_rdata, cpu_rvalid
  );
endinterface

// File: rtl/vram_port_arbiter_m.sv
// Arbitrates video-read and CPU ports onto an async SRAM; read data 2 cycles after accept, writes take 4 cycles.
// *_ready is high only in IDLE for the grant winner; define VRAM_RR_ARB_EN for round-robin instead of video priority.
module vram_port_arbiter_m #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vram_port_arbiter_m_if.slave  req,
  output logic [ADDR_WIDTH-1:0] sram_address,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_WE,
  output logic                  sram_OE,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETUP  = 3'd1,
    RD_SAMPLE = 3'd2,
    WR_SETUP  = 3'd3,
    WR_STROBE = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  grant_vid;
  logic                  grant_cpu;
  logic                  vid_rdy;
  logic                  cpu_rdy;
  logic                  we_d;
  logic                  oe_d;
  logic                  drive_d;
  logic                  drive_q;
  logic                  sel_cpu_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] vid_rdata_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic                  vid_rvalid_q;
  logic                  cpu_rvalid_q;

`ifdef VRAM_RR_ARB_EN
  // last_cpu_q remembers who won the last contested grant; starts as CPU so video wins first.
  logic last_cpu_q;
  logic contest;

  assign contest = req.vid_valid & req.cpu_valid;

  always_comb begin
    grant_vid = req.vid_valid & (~req.cpu_valid | last_cpu_q);
    grant_cpu = req.cpu_valid & (~req.vid_valid | ~last_cpu_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cpu_q <= 1'b1;
    end else if (contest && (vid_rdy || cpu_rdy)) begin
      last_cpu_q <= cpu_rdy;
    end
  end
`else
  always_comb begin
    grant_vid = req.vid_valid;
    grant_cpu = req.cpu_valid & ~req.vid_valid;
  end
`endif

  assign vid_rdy = (state_q == IDLE) & grant_vid;
  assign cpu_rdy = (state_q == IDLE) & grant_cpu;

  // SRAM strobes are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sram_WE <= 1'b0;
      sram_OE <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sram_WE <= we_d;
      sram_OE <= oe_d;
      drive_q <= drive_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vid_rdy) begin
          state_d = RD_SETUP;
        end else if (cpu_rdy) begin
          state_d = req.cpu_we ? WR_SETUP : RD_SETUP;
        end
      end
      RD_SETUP:  state_d = RD_SAMPLE;
      RD_SAMPLE: state_d = IDLE;
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Decoded from the next state so the registered strobes line up with it.
  always_comb begin
    oe_d    = 1'b0;
    we_d    = 1'b0;
    drive_d = 1'b0;
    case (state_d)
      RD_SETUP, RD_SAMPLE: oe_d = 1'b1;
      WR_SETUP, WR_HOLD:   drive_d = 1'b1;
      WR_STROBE: begin
        drive_d = 1'b1;
        we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_cpu_q    <= 1'b0;
      sram_address <= '0;
      wdata_q      <= '0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      if (vid_rdy) begin
        sel_cpu_q    <= 1'b0;
        sram_address <= req.vid_addr;
      end else if (cpu_rdy) begin
        sel_cpu_q    <= 1'b1;
        sram_address <= req.cpu_addr;
        wdata_q      <= req.cpu_wdata;
      end
      if (state_q == RD_SAMPLE) begin
        if (sel_cpu_q) begin
          cpu_rdata_q  <= sram_data;
          cpu_rvalid_q <= 1'b1;
        end else begin
          vid_rdata_q  <= sram_data;
          vid_rvalid_q <= 1'b1;
        end
      end
    end
  end

  assign sram_data      = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign busy           = (state_q != IDLE);
  assign req.vid_ready  = vid_rdy;
  assign req.cpu_ready  = cpu_rdy;
  assign req.vid_rdata  = vid_rdata_q;
  assign req.vid_rvalid = vid_rvalid_q;
  assign req.cpu_rdata  = cpu_rdata_q;
  assign req.cpu_rvalid = cpu_rvalid_q;

  a_we_oe_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(sram_WE && sram_OE));

endmodule

// File: tb/tb_vram_port_arbiter_m.sv
// Bench for vram_port_arbiter_m: async SRAM model plus a transaction-level reference model checked every cycle.
// Directed scenarios first, then randomized traffic; build with VRAM_RR_ARB_EN to check round-robin.
module tb_vram_port_arbiter_m;
  localparam int DW    = 8;
  localparam int AW    = 15;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_address;
  logic          sram_WE;
  logic          sram_OE;
  logic          busy;

  vram_port_arbiter_m_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) req_if ();

  vram_port_arbiter_m #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req_if),
    .sram_address (sram_address),
    .sram_data    (sram_data),
    .sram_WE      (sram_WE),
    .sram_OE      (sram_OE),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Async SRAM device; a released bus reads back as all ones through the pullups.
  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] sram_rd;
  assign sram_rd   = sram_mem[sram_address];
  assign sram_data = (sram_OE && !sram_WE) ? sram_rd : {DW{1'bz}};
  for (genvar b = 0; b < DW; b++) begin : g_pu
    pullup (sram_data[b]);
  end
  always @(negedge clk) if (sram_WE) sram_mem[sram_address] = sram_data;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Reference model: each accept books fixed-length bus windows and a response cycle.
  logic [DW-1:0] ref_mem [DEPTH];
  int            busy_cnt, vid_resp_at, cpu_resp_at, rd_end, wr_end, we_at;
  logic [DW-1:0] vid_resp_dat, cpu_resp_dat, vid_rdata_exp, cpu_rdata_exp, wr_dat;
  logic [AW-1:0] exp_addr;
  bit            last_cpu, vw, cw, in_rd, in_wr;
  int            we_high_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0; vid_resp_at = -1; cpu_resp_at = -1; rd_end = -1; wr_end = -1; we_at = -1;
      vid_rdata_exp = '0; cpu_rdata_exp = '0; exp_addr = '0; last_cpu = 1'b1;
      check("rst_we", sram_WE, 0);
      check("rst_oe", sram_OE, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", sram_address, 0);
      check("rst_data_z", sram_data, 8'hFF);
      check("rst_vid_rvalid", req_if.vid_rvalid, 0);
      check("rst_cpu_rvalid", req_if.cpu_rvalid, 0);
      check("rst_vid_rdata", req_if.vid_rdata, 0);
      check("rst_cpu_rdata", req_if.cpu_rdata, 0);
    end else begin
      in_rd = (cyc >= rd_end - 1) && (cyc <= rd_end);
      in_wr = (cyc >= wr_end - 2) && (cyc <= wr_end);
      if (cyc == vid_resp_at) vid_rdata_exp = vid_resp_dat;
      if (cyc == cpu_resp_at) cpu_rdata_exp = cpu_resp_dat;
      if (cyc == we_at) ref_mem[exp_addr] = wr_dat;
      if (sram_WE) we_high_cnt++;
      check("busy", busy, busy_cnt != 0);
      check("oe", sram_OE, in_rd);
      check("we", sram_WE, cyc == we_at);
      check("we_oe_excl", sram_WE & sram_OE, 0);
      check("addr", sram_address, exp_addr);
      if (in_wr) check("wr_data", sram_data, wr_dat);
      else if (!in_rd) check("data_z", sram_data, 8'hFF);
      check("vid_rvalid", req_if.vid_rvalid, cyc == vid_resp_at);
      check("cpu_rvalid", req_if.cpu_rvalid, cyc == cpu_resp_at);
      check("vid_rdata", req_if.vid_rdata, vid_rdata_exp);
      check("cpu_rdata", req_if.cpu_rdata, cpu_rdata_exp);
      vw = 1'b0;
      cw = 1'b0;
      if (busy_cnt == 0) begin
`ifdef VRAM_RR_ARB_EN
        if (req_if.vid_valid && req_if.cpu_valid) begin
          vw = last_cpu;
          cw = !last_cpu;
          last_cpu = cw;
        end else begin
          vw = req_if.vid_valid;
          cw = req_if.cpu_valid;
        end
`else
        vw = req_if.vid_valid;
        cw = req_if.cpu_valid && !req_if.vid_valid;
`endif
      end
      check("vid_ready", req_if.vid_ready, vw);
      check("cpu_ready", req_if.cpu_ready, cw);
      if (vw) begin
        busy_cnt = 2; rd_end = cyc + 2; vid_resp_at = cyc + 3;
        exp_addr = req_if.vid_addr; vid_resp_dat = ref_mem[req_if.vid_addr];
      end else if (cw && req_if.cpu_we) begin
        busy_cnt = 3; wr_end = cyc + 3; we_at = cyc + 2;
        exp_addr = req_if.cpu_addr; wr_dat = req_if.cpu_wdata;
      end else if (cw) begin
        busy_cnt = 2; rd_end = cyc + 2; cpu_resp_at = cyc + 3;
        exp_addr = req_if.cpu_addr; cpu_resp_dat = ref_mem[req_if.cpu_addr];
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
    end
    cyc++;
  end

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom);
  endfunction

  task automatic cpu_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bit done = 1'b0;
    req_if.cpu_valid = 1'b1;
    req_if.cpu_we    = we;
    req_if.cpu_addr  = addr;
    req_if.cpu_wdata = wdata;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = req_if.cpu_ready;
      @(posedge clk); #1;
    end
    req_if.cpu_valid = 1'b0;
    req_if.cpu_addr  = pick_addr();
    req_if.cpu_wdata = DW'($urandom);
    check("cpu_accept", done, 1);
  endtask

  task automatic vid_req(input logic [AW-1:0] addr);
    bit done = 1'b0;
    req_if.vid_valid = 1'b1;
    req_if.vid_addr  = addr;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = req_if.vid_ready;
      @(posedge clk); #1;
    end
    req_if.vid_valid = 1'b0;
    req_if.vid_addr  = pick_addr();
    check("vid_accept", done, 1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int            w0, n_g, n_acc;
  bit            grants [6];
  int            acc_cyc [2];
  logic [DW-1:0] pre_val;

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      sram_mem[a] = DW'($urandom);
      ref_mem[a]  = sram_mem[a];
    end
    req_if.vid_valid = 1'b0; req_if.vid_addr = '0;
    req_if.cpu_valid = 1'b0; req_if.cpu_we = 1'b0; req_if.cpu_addr = '0; req_if.cpu_wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(5);
    check("idle_busy", busy, 0);
    check("idle_we", sram_WE, 0);
    check("idle_oe", sram_OE, 0);

    // Write then read back the same location.
    w0 = we_high_cnt;
    cpu_req(1'b1, 15'h1234, 8'hA5);
    step(3);
    check("wr_we_one_cycle", we_high_cnt - w0, 1);
    cpu_req(1'b0, 15'h1234, 8'h00);
    step(1);
    check("rd_rvalid_early", req_if.cpu_rvalid, 0);
    step(1);
    check("rd_rvalid", req_if.cpu_rvalid, 1);
    check("rd_data", req_if.cpu_rdata, 8'hA5);
    step(2);

    // Both ports held valid for six grants.
    req_if.vid_valid = 1'b1; req_if.vid_addr = pick_addr();
    req_if.cpu_valid = 1'b1; req_if.cpu_we = 1'b0; req_if.cpu_addr = pick_addr();
    n_g = 0;
    for (int i = 0; i < 80 && n_g < 6; i++) begin
      @(negedge clk);
      if (req_if.vid_ready) begin grants[n_g] = 1'b0; n_g++; end
      else if (req_if.cpu_ready) begin grants[n_g] = 1'b1; n_g++; end
      @(posedge clk); #1;
    end
    req_if.vid_valid = 1'b0; req_if.cpu_valid = 1'b0;
    check("grant_count", n_g, 6);
    for (int i = 0; i < n_g; i++) begin
`ifdef VRAM_RR_ARB_EN
      check("grant_order", grants[i], i % 2);
`else
      check("grant_order", grants[i], 0);
`endif
    end
    step(4);

    // Write followed by video read of the same address.
    cpu_req(1'b1, 15'h0200, 8'h3C);
    vid_req(15'h0200);
    step(3);
    check("wr_then_vid_rdata", req_if.vid_rdata, 8'h3C);

    // Reset during the write strobe.
    pre_val = ref_mem[15'h0ABC];
    cpu_req(1'b1, 15'h0ABC, ~pre_val);
    step(1);
    check("we_before_rst", sram_WE, 1);
    rst_n = 1'b0;
    #1;
    check("we_async_drop", sram_WE, 0);
    check("busy_async_drop", busy, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    cpu_req(1'b0, 15'h0ABC, 8'h00);
    step(3);
    check("aborted_wr_rdata", req_if.cpu_rdata, pre_val);

    // Back-to-back video reads at both ends of the address space.
    req_if.vid_valid = 1'b1; req_if.vid_addr = 15'h0000;
    n_acc = 0;
    for (int i = 0; i < 30 && n_acc < 2; i++) begin
      @(negedge clk);
      if (req_if.vid_ready) begin acc_cyc[n_acc] = i; n_acc++; end
      @(posedge clk); #1;
      if (n_acc == 1) req_if.vid_addr = 15'h7FFF;
    end
    req_if.vid_valid = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 3);
    step(3);
    check("b2b_rdata_top", req_if.vid_rdata, sram_mem[15'h7FFF]);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      req_if.vid_valid = ($urandom_range(0, 2) == 0);
      req_if.vid_addr  = pick_addr();
      req_if.cpu_valid = 1'($urandom_range(0, 1));
      req_if.cpu_we    = 1'($urandom_range(0, 1));
      req_if.cpu_addr  = pick_addr();
      req_if.cpu_wdata = DW'($urandom);
      step(1);
    end
    req_if.vid_valid = 1'b0; req_if.cpu_valid = 1'b0;
    step(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
